saturating_sub_stream: RTL

- Streaming counterpart of the 8-bit unsigned saturating adder: a loadable accumulator that saturating-subtracts each accepted input sample and floors at 0 instead of wrapping.
- Sits between a credit/budget source and a consumer. Emits the running remainder after every subtraction over a valid/ready output.
- Stops accepting input once the remainder reaches 0.

---
 rtl/saturating_pkg.sv | 31 +++
 rtl/saturating_sub_stream_sat_counter.sv | 23 ++
 rtl/saturating_sub_stream.sv | 85 ++++++++
 3 files changed

// File: rtl/saturating_pkg.sv
// Shared types and width-generic saturating arithmetic helpers.
// Pure combinational functions; no state, latency or flow control here.
package saturating_pkg;

    typedef enum logic [1:0] {IDLE, RUN, EMPTY} state_t;

    // Static-only wrapper so one function body serves every operand width.
    virtual class sat_math #(parameter int W = 8);

        typedef struct packed {
            logic [W-1:0] value;
            logic         clamped;
        } sub_t;

        // Subtract at W+1 bits; a borrow floors the result at zero.
        static function sub_t sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
            logic [W:0] diff;
            sub_t       r;
            diff      = {1'b0, a} - {1'b0, b};
            r.clamped = diff[W];
            r.value   = diff[W] ? '0 : diff[W-1:0];
            return r;
        endfunction

        static function logic [W-1:0] sat_inc(input logic [W-1:0] v);
            return (&v) ? v : v + 1'b1;
        endfunction

    endclass

endpackage

// File: rtl/saturating_sub_stream_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
// Count updates one cycle after inc; no flow control (inc is never refused).
module sat_counter
    import saturating_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_math#(W)::sat_inc(count);
        end
    end

endmodule

// File: rtl/saturating_sub_stream.sv
// Loadable accumulator that saturating-subtracts each accepted sample, flooring at 0.
// Latency 1 cycle accept-to-out_valid; in_ready drops while a result is stalled or budget is spent.
module saturating_sub_stream
    import saturating_pkg::*;
#(
    parameter int WIDTH             = 8,
    parameter int CLAMP_CNT_W       = 4,
    parameter bit LOAD_CLEARS_COUNT = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_value,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_clamped,
    output logic                   empty,
    output logic [CLAMP_CNT_W-1:0] clamp_count
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sub_value;
    logic             sub_clamped;
    logic             accept;

    assign {sub_value, sub_clamped} = sat_math#(WIDTH)::sat_sub(acc_q, in_data);

    // A stalled result blocks new input so the held output is never overwritten.
    assign in_ready = (state_q == RUN) && !load && !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign empty    = (state_q != RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_value != '0) ? RUN : EMPTY;
        end else if (accept && (sub_value == '0)) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_clamped <= 1'b0;
        end else if (load) begin
            acc_q     <= load_value;
            out_valid <= 1'b0;
        end else if (accept) begin
            acc_q       <= sub_value;
            out_data    <= sub_value;
            out_clamped <= sub_clamped;
            out_valid   <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    sat_counter #(
        .W (CLAMP_CNT_W)
    ) u_clamp_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (load && LOAD_CLEARS_COUNT),
        .inc   (accept && sub_clamped),
        .count (clamp_count)
    );

endmodule
